axis_frame_fifo: RTL and testbench

- Downstream consumer of the 2:1 AXI-stream mux stage.
- Accepts 8-bit beats with tlast, buffers them in a synchronous FIFO, and re-emits them on an AXI-stream master port with correct valid/ready backpressure.
- Tracks accepted and delivered frame counts and fill level, so the mux output can be throttled and frame boundaries preserved.

---
 rtl/axis_pkg.sv | 13 +
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/axis_frame_fifo.sv | 139 +++++++++++++
 tb/tb_axis_frame_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared constants and the stored-entry type for the AXI-stream frame FIFO.
package axis_pkg;

  localparam int unsigned AXIS_DATA_W     = 8;
  localparam int unsigned AXIS_FIFO_DEPTH = 16;
  localparam int unsigned AXIS_CNT_W      = 5;

  typedef struct packed {
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;
  } axis_entry_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous (fall-through) read.
module sync_fifo_mem
  import axis_pkg::*;
#(
  parameter int unsigned WIDTH = AXIS_DATA_W + 1,
  parameter int unsigned DEPTH = AXIS_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_frame_fifo.sv
// AXI-stream FIFO with frame counters; DEPTH must be a power of two (>= 4).
// Define AXIS_FIFO_STORE_FWD_EN to hold output until a whole frame is stored.
module axis_frame_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_DATA_W,
  parameter int unsigned DEPTH  = AXIS_FIFO_DEPTH,
  parameter int unsigned CNT_W  = AXIS_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [DATA_W-1:0]      m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       in_frame_cnt,
  output logic [CNT_W-1:0]       out_frame_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [DATA_W:0]   rd_word;
  logic              wr_en, rd_en, empty, full;

  assign empty = (level_q == '0);
  assign full  = (level_q == FullLvl);

  // Ready depends only on registered level, never on m_tready.
  assign s_tready = !full;
  assign wr_en    = s_tvalid && s_tready;
  assign rd_en    = m_tvalid && m_tready;

  sync_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data ({s_tlast, s_tdata}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  assign m_tlast = rd_word[DATA_W];
  assign m_tdata = rd_word[DATA_W-1:0];

`ifdef AXIS_FIFO_STORE_FWD_EN
  logic [LvlW-1:0] frames_q, frames_d;
  logic            out_active_q, out_active_d;

  // Full override releases frames longer than the FIFO; out_active keeps a
  // started frame flowing until its last beat leaves.
  assign m_tvalid = !empty && ((frames_q != '0) || full || out_active_q);

  always_comb begin
    frames_d     = frames_q;
    out_active_d = out_active_q;
    unique case ({wr_en && s_tlast, rd_en && m_tlast})
      2'b10:   frames_d = frames_q + LvlW'(1);
      2'b01:   frames_d = frames_q - LvlW'(1);
      default: frames_d = frames_q;
    endcase
    if (rd_en) begin
      out_active_d = !m_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_q     <= '0;
      out_active_q <= 1'b0;
    end else begin
      frames_q     <= frames_d;
      out_active_q <= out_active_d;
    end
  end
`else
  assign m_tvalid = !empty;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (s_tlast) begin
        in_cnt_d = in_cnt_q + CNT_W'(1);
      end
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (m_tlast) begin
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end
    end
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign level         = level_q;
  assign in_frame_cnt  = in_cnt_q;
  assign out_frame_cnt = out_cnt_q;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Self-checking bench for axis_frame_fifo against a queue-based frame model.
module tb_axis_frame_fifo;
  import axis_pkg::*;

  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int CNT_M  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tready;
  logic [4:0] level;
  logic [CNT_W-1:0] in_frame_cnt, out_frame_cnt;

  axis_frame_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tlast       (m_tlast),
    .m_tready      (m_tready),
    .level         (level),
    .in_frame_cnt  (in_frame_cnt),
    .out_frame_cnt (out_frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  axis_entry_t q[$];
  int  exp_in = 0;
  int  exp_out = 0;
  bit  out_active = 0;
  bit  hold_pend = 0;
  logic [7:0] hold_data;
  bit  last_wr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_valid();
    int frames = 0;
    if (q.size() == 0) return 0;
`ifdef AXIS_FIFO_STORE_FWD_EN
    foreach (q[i]) if (q[i].last) frames++;
    return (frames > 0) || (q.size() == DEPTH) || out_active;
`else
    return 1;
`endif
  endfunction

  // Called at a negedge with inputs already driven: check, update model, advance.
  task automatic tick();
    bit ev, wr, rd;
    axis_entry_t e;
    ev = model_valid();
    chk("m_tvalid", m_tvalid, ev);
    chk("s_tready", s_tready, q.size() != DEPTH);
    chk("level", level, q.size());
    chk("in_frame_cnt", in_frame_cnt, exp_in);
    chk("out_frame_cnt", out_frame_cnt, exp_out);
    if (ev) begin
      chk("m_tdata", m_tdata, q[0].data);
      chk("m_tlast", m_tlast, q[0].last);
    end
    if (hold_pend) begin
      chk("hold_valid", m_tvalid, 1);
      chk("hold_data", m_tdata, hold_data);
    end
    wr = s_tvalid && (q.size() != DEPTH);
    rd = ev && m_tready;
    if (reset) begin
      q.delete();
      exp_in = 0;
      exp_out = 0;
      out_active = 0;
      hold_pend = 0;
      last_wr = 0;
    end else begin
      hold_pend = ev && !m_tready;
      if (ev) hold_data = q[0].data;
      if (rd) begin
        e = q.pop_front();
        if (e.last) exp_out = (exp_out + 1) & CNT_M;
        out_active = !e.last;
      end
      if (wr) begin
        e.last = s_tlast;
        e.data = s_tdata;
        q.push_back(e);
        if (s_tlast) exp_in = (exp_in + 1) & CNT_M;
      end
      last_wr = wr;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = r;
    tick();
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic r);
    int n = 0;
    do begin
      drive(1'b1, d, l, r);
      n++;
    end while (!last_wr && n < 200);
    chk("push_timeout", last_wr, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend, released;
    logic [7:0] pd;
    logic pl;
    int sent, n;

    reset = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = 8'h00;
    s_tlast = 1'b0;
    m_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_level", level, 0);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_in_cnt", in_frame_cnt, 0);
    chk("rst_out_cnt", out_frame_cnt, 0);

    // One three-beat frame with the consumer always ready
    push(8'h11, 1'b0, 1'b1);
`ifndef AXIS_FIFO_STORE_FWD_EN
    chk("fwft_latency", m_tvalid, 1);
    chk("fwft_data", m_tdata, 8'h11);
`endif
    push(8'h22, 1'b0, 1'b1);
    push(8'h33, 1'b1, 1'b1);
    drain();
    chk("frame1_in_cnt", in_frame_cnt, 1);
    chk("frame1_out_cnt", out_frame_cnt, 1);

    // Fill to full, then hold a 17th beat until space frees
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0);
    chk("full_level", level, 16);
    chk("full_s_tready", s_tready, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hAA, 1'b1, 1'b0);
      chk("full_no_accept", last_wr, 0);
    end
    push(8'hAA, 1'b1, 1'b1);
    drain();

    // Simultaneous read/write at level 5
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), i == 4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'h60 + 8'(i), 1'b1, 1'b1);
      chk("rw_level", level, 5);
    end
    drain();

    // Random backpressure over a 40-beat stream
    sent = 0;
    pend = 0;
    n = 0;
    while ((sent < 40 || q.size() != 0) && n < 2000) begin
      if (!pend && sent < 40 && $urandom_range(0, 3) != 0) begin
        pend = 1;
        pd = 8'($urandom);
        pl = (sent == 39) || ($urandom_range(0, 3) == 0);
      end
      drive(pend, pd, pl, 1'($urandom_range(0, 1)));
      if (last_wr) begin
        pend = 0;
        sent++;
      end
      n++;
    end
    chk("random_done", sent + q.size() * 100, 40);

    // Counter wrap: 33 single-beat frames from a clean reset
    do_reset();
    for (int i = 0; i < 33; i++) push(8'($urandom), 1'b1, 1'b1);
    drain();
    chk("wrap_in_cnt", in_frame_cnt, 1);
    chk("wrap_out_cnt", out_frame_cnt, 1);

`ifdef AXIS_FIFO_STORE_FWD_EN
    // Output held back until the frame's last beat is stored
    for (int i = 0; i < 4; i++) begin
      push(8'h70 + 8'(i), 1'b0, 1'b1);
      chk("sf_hold_valid", m_tvalid, 0);
    end
    push(8'h74, 1'b1, 1'b1);
    chk("sf_release_valid", m_tvalid, 1);
    drain();

    // Over-long frame released at full, then reset mid-frame
    released = 0;
    for (int i = 0; i < 18; i++) begin
      if (m_tvalid && !released) begin
        chk("sf_release_level", level, 16);
        released = 1;
      end
      push(8'h80 + 8'(i), 1'b0, 1'b1);
    end
    chk("sf_released", released, 1);
    do_reset();
    chk("midrst_level", level, 0);
    chk("midrst_valid", m_tvalid, 0);
    push(8'h99, 1'b1, 1'b1);
    drain();
`endif

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
